// File: rtl/brc_arb_if.sv
// Request/response bundle between branch requesters and the shared branch-resolution arbiter.
// master: requester side (branch unit, debug/trace compare); slave: brc_arb.
interface brc_arb_if;
    logic [1:0]  i_req_valid;
    logic [1:0]  o_req_ready;
    logic [63:0] i_req_rs1;
    logic [63:0] i_req_rs2;
    logic [5:0]  i_req_funct3;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic        o_rsp_id;
    logic        o_rsp_taken;
    logic        o_rsp_less;
    logic        o_rsp_equal;
    logic        o_rsp_illegal;

    modport master (
        output i_req_valid, i_req_rs1, i_req_rs2, i_req_funct3, i_rsp_ready,
        input  o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_taken, o_rsp_less,
               o_rsp_equal, o_rsp_illegal
    );

    modport slave (
        input  i_req_valid, i_req_rs1, i_req_rs2, i_req_funct3, i_rsp_ready,
        output o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_taken, o_rsp_less,
               o_rsp_equal, o_rsp_illegal
    );
endinterface

// File: rtl/brc_arb.sv
// Two-port round-robin branch-resolution controller around the brc comparator.
// Optional response statistics counters are built when BRC_ARB_STATS_EN is defined.
//
// state  | meaning
// IDLE   | arbitrate requesters, latch the granted request
// CMP    | latched operands drive brc, capture flags and decode
// RESP   | hold registered response until i_rsp_ready

module brc (
    input  logic        i_br_un,
    input  logic [31:0] i_rs1,
    input  logic [31:0] i_rs2,
    output logic        o_br_less,
    output logic        o_br_equal
);
    // i_br_un = 1 selects a signed compare
    assign o_br_equal = (i_rs1 == i_rs2);
    assign o_br_less  = i_br_un ? ($signed(i_rs1) < $signed(i_rs2)) : (i_rs1 < i_rs2);
endmodule

module brc_arb #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    brc_arb_if.slave         bus,
    output logic [CNT_W-1:0] o_stat_total,
    output logic [CNT_W-1:0] o_stat_taken
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMP  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]  r_state;
    logic        r_last;
    logic [31:0] r_rs1;
    logic [31:0] r_rs2;
    logic [2:0]  r_funct3;
    logic        r_id;
    logic        r_taken;
    logic        r_less;
    logic        r_equal;
    logic        r_illegal;

    logic [1:0]  w_grant;
    logic [1:0]  w_ready;
    logic        w_accept;
    logic        w_accept_id;
    logic        w_br_un;
    logic        w_br_less;
    logic        w_br_equal;
    logic        w_taken;
    logic        w_illegal;

    // On a tie the requester that did not win last time is granted
    always_comb begin
        w_grant = bus.i_req_valid;
        if (bus.i_req_valid == 2'b11) begin
            w_grant = r_last ? 2'b01 : 2'b10;
        end
    end

    assign w_ready         = (r_state == S_IDLE) ? w_grant : 2'b00;
    assign w_accept        = |(bus.i_req_valid & w_ready);
    assign w_accept_id     = w_ready[1];
    assign bus.o_req_ready = w_ready;

    always_comb begin
        w_br_un = 1'b1;
        if (r_funct3 == 3'b110 || r_funct3 == 3'b111) begin
            w_br_un = 1'b0;
        end
    end

    brc u_brc (
        .i_br_un    (w_br_un),
        .i_rs1      (r_rs1),
        .i_rs2      (r_rs2),
        .o_br_less  (w_br_less),
        .o_br_equal (w_br_equal)
    );

    always_comb begin
        w_taken   = 1'b0;
        w_illegal = 1'b0;
        case (r_funct3)
            3'b000:          w_taken = w_br_equal;
            3'b001:          w_taken = ~w_br_equal;
            3'b100, 3'b110:  w_taken = w_br_less;
            3'b101, 3'b111:  w_taken = ~w_br_less;
            default:         w_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_last    <= 1'b1;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_funct3  <= '0;
            r_id      <= 1'b0;
            r_taken   <= 1'b0;
            r_less    <= 1'b0;
            r_equal   <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_rs1    <= w_accept_id ? bus.i_req_rs1[63:32] : bus.i_req_rs1[31:0];
                        r_rs2    <= w_accept_id ? bus.i_req_rs2[63:32] : bus.i_req_rs2[31:0];
                        r_funct3 <= w_accept_id ? bus.i_req_funct3[5:3] : bus.i_req_funct3[2:0];
                        r_id     <= w_accept_id;
                        r_last   <= w_accept_id;
                        r_state  <= S_CMP;
                    end
                end
                S_CMP: begin
                    r_taken   <= w_taken;
                    r_less    <= w_br_less;
                    r_equal   <= w_br_equal;
                    r_illegal <= w_illegal;
                    r_state   <= S_RESP;
                end
                S_RESP: begin
                    if (bus.i_rsp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_rsp_valid   = (r_state == S_RESP);
    assign bus.o_rsp_id      = r_id;
    assign bus.o_rsp_taken   = r_taken;
    assign bus.o_rsp_less    = r_less;
    assign bus.o_rsp_equal   = r_equal;
    assign bus.o_rsp_illegal = r_illegal;

`ifdef BRC_ARB_STATS_EN
    logic [CNT_W-1:0] r_stat_total;
    logic [CNT_W-1:0] r_stat_taken;
    logic             w_rsp_fire;

    assign w_rsp_fire = (r_state == S_RESP) && bus.i_rsp_ready;

    // Saturating counters; they stop at all-ones rather than wrap
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_stat_total <= '0;
            r_stat_taken <= '0;
        end else if (w_rsp_fire) begin
            if (r_stat_total != {CNT_W{1'b1}}) begin
                r_stat_total <= r_stat_total + 1'b1;
            end
            if (r_taken && (r_stat_taken != {CNT_W{1'b1}})) begin
                r_stat_taken <= r_stat_taken + 1'b1;
            end
        end
    end

    assign o_stat_total = r_stat_total;
    assign o_stat_taken = r_stat_taken;
`else
    assign o_stat_total = '0;
    assign o_stat_taken = '0;
`endif
endmodule

// File: tb/tb_brc_arb.sv
// Bench for brc_arb: directed scenarios plus randomized traffic against a transaction-level model.
module tb_brc_arb;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] stat_total;
    logic [15:0] stat_taken;

    brc_arb_if bus();

    brc_arb #(.CNT_W(16)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .bus          (bus),
        .o_stat_total (stat_total),
        .o_stat_taken (stat_taken)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: what a branch with these operands must resolve to -> {taken, less, equal, illegal}
    function automatic logic [3:0] ref_rsp(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
        logic sgn, lt, eq, tk, ill;
        sgn = (f != 3'b110) && (f != 3'b111);
        lt  = sgn ? ($signed(a) < $signed(b)) : (a < b);
        eq  = (a == b);
        tk  = 1'b0;
        ill = 1'b0;
        case (f)
            3'd0: tk = eq;
            3'd1: tk = !eq;
            3'd4, 3'd6: tk = lt;
            3'd5, 3'd7: tk = !lt;
            default: ill = 1'b1;
        endcase
        return {tk, lt, eq, ill};
    endfunction

    // Transaction model: one outstanding request, its age in edges since acceptance
    bit          m_known = 0;
    bit          m_pend  = 0;
    int          m_age   = 0;
    bit          m_last  = 1;
    bit          m_id    = 0;
    logic [3:0]  m_rsp   = 4'b0;
    int unsigned m_total = 0;
    int unsigned m_tcnt  = 0;

    function automatic logic [1:0] exp_ready();
        if (m_pend) return 2'b00;
        if (bus.i_req_valid == 2'b11) return m_last ? 2'b01 : 2'b10;
        return bus.i_req_valid;
    endfunction

    initial forever begin
        logic [1:0] g;
        @(posedge clk);
        if (rst) begin
            m_known = 1; m_pend = 0; m_last = 1; m_total = 0; m_tcnt = 0;
        end else if (m_known) begin
            if (m_pend) begin
                if (m_age >= 1 && bus.i_rsp_ready) begin
                    m_pend = 0;
                    if (m_total < 32'hFFFF) m_total++;
                    if (m_rsp[3] && m_tcnt < 32'hFFFF) m_tcnt++;
                end else begin
                    m_age++;
                end
            end else begin
                g = exp_ready() & bus.i_req_valid;
                if (g != 2'b00) begin
                    m_id   = g[1];
                    m_rsp  = ref_rsp(bus.i_req_rs1[m_id*32 +: 32], bus.i_req_rs2[m_id*32 +: 32],
                                     bus.i_req_funct3[m_id*3 +: 3]);
                    m_last = m_id;
                    m_pend = 1;
                    m_age  = 0;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (m_known && !rst) begin
            check("req_ready", bus.o_req_ready, exp_ready());
            check("ready_onehot", ($countones(bus.o_req_ready) <= 1), 1);
            check("rsp_valid", bus.o_rsp_valid, (m_pend && m_age >= 1));
            if (m_pend && m_age >= 1) begin
                check("rsp_id", bus.o_rsp_id, m_id);
                check("rsp_fields", {bus.o_rsp_taken, bus.o_rsp_less, bus.o_rsp_equal, bus.o_rsp_illegal}, m_rsp);
            end
`ifdef BRC_ARB_STATS_EN
            check("stat_total", stat_total, m_total);
            check("stat_taken", stat_taken, m_tcnt);
`else
            check("stat_total_off", stat_total, 0);
            check("stat_taken_off", stat_taken, 0);
`endif
        end
    end

    task automatic drive_req(input int r, input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
        bus.i_req_rs1[r*32 +: 32]  = a;
        bus.i_req_rs2[r*32 +: 32]  = b;
        bus.i_req_funct3[r*3 +: 3] = f;
        bus.i_req_valid[r]         = 1'b1;
    endtask

    task automatic wait_rsp();
        int k = 0;
        @(negedge clk);
        while (!bus.o_rsp_valid && k < 20) begin @(negedge clk); k++; end
        if (k >= 20) check("rsp_timeout", bus.o_rsp_valid, 1);
    endtask

    task automatic run_one(input int r, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] f, output logic [3:0] res);
        int k = 0;
        @(posedge clk); #1;
        drive_req(r, a, b, f);
        @(negedge clk);
        while (!bus.o_req_ready[r] && k < 20) begin @(negedge clk); k++; end
        if (k >= 20) check("accept_timeout", bus.o_req_ready[r], 1);
        @(posedge clk); #1;
        bus.i_req_valid[r] = 1'b0;
        wait_rsp();
        res = {bus.o_rsp_taken, bus.o_rsp_less, bus.o_rsp_equal, bus.o_rsp_illegal};
        bus.i_rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.i_rsp_ready = 1'b0;
    endtask

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [3:0]  res;
        logic [1:0]  acc;
        logic [31:0] a;
        int          k;
        rst = 1'b1;
        bus.i_req_valid  = 2'b00;
        bus.i_req_rs1    = '0;
        bus.i_req_rs2    = '0;
        bus.i_req_funct3 = '0;
        bus.i_rsp_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_ready", bus.o_req_ready, 2'b00);
        check("rst_rsp", {bus.o_rsp_valid, bus.o_rsp_id, bus.o_rsp_taken, bus.o_rsp_less,
                          bus.o_rsp_equal, bus.o_rsp_illegal}, 6'b0);
        check("rst_stats", {stat_total, stat_taken}, 32'h0);
        check("model_beq", ref_rsp(32'd5, 32'd5, 3'b000), 4'b1010);
        check("model_blt", ref_rsp(32'h1, 32'hFFFF_FFFF, 3'b100), 4'b0000);
        check("model_bltu", ref_rsp(32'h1, 32'hFFFF_FFFF, 3'b110), 4'b1100);
        check("model_ill", ref_rsp(32'h8000_0000, 32'h8000_0000, 3'b011), 4'b0011);

        // First transaction timing and a long response stall
        @(posedge clk); #1;
        drive_req(0, 32'd5, 32'd5, 3'b000);
        @(negedge clk);
        check("t1_ready", bus.o_req_ready, 2'b01);
        @(posedge clk); #1;
        bus.i_req_valid = 2'b00;
        @(negedge clk);
        check("t1_cmp_novalid", bus.o_rsp_valid, 0);
        @(negedge clk);
        check("t1_rsp", {bus.o_rsp_valid, bus.o_rsp_id, bus.o_rsp_taken, bus.o_rsp_less,
                         bus.o_rsp_equal, bus.o_rsp_illegal}, 6'b101010);
        @(posedge clk); #1;
        drive_req(1, 32'd3, 32'd3, 3'b000);
        drive_req(0, 32'd5, 32'd5, 3'b000);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_rsp", {bus.o_rsp_valid, bus.o_rsp_id, bus.o_rsp_taken, bus.o_rsp_less,
                               bus.o_rsp_equal, bus.o_rsp_illegal}, 6'b101010);
            check("hold_ready", bus.o_req_ready, 2'b00);
        end
        bus.i_rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.i_rsp_ready = 1'b0;
        @(negedge clk);
        check("release_idle", bus.o_rsp_valid, 0);
        check("release_ready", bus.o_req_ready, 2'b10);
        @(posedge clk); #1;
        bus.i_req_valid = 2'b00;
        wait_rsp();
        check("t1b_id", bus.o_rsp_id, 1);
        bus.i_rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.i_rsp_ready = 1'b0;

        run_one(1, 32'h1, 32'hFFFF_FFFF, 3'b100, res);
        check("blt_signed", res, 4'b0000);
        run_one(1, 32'h1, 32'hFFFF_FFFF, 3'b110, res);
        check("bltu_unsigned", res, 4'b1100);
        run_one(0, 32'h8000_0000, 32'h8000_0000, 3'b011, res);
        check("illegal", res, 4'b0011);
        @(negedge clk);
`ifdef BRC_ARB_STATS_EN
        check("stat_total_dir", stat_total, 16'd5);
        check("stat_taken_dir", stat_taken, 16'd3);
`else
        check("stat_off_dir", {stat_total, stat_taken}, 32'h0);
`endif

        // Continuous contention after reset: grants must alternate starting with 0
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        drive_req(0, 32'h10, 32'h20, 3'b001);
        drive_req(1, 32'h30, 32'h31, 3'b001);
        for (int i = 0; i < 4; i++) begin
            k = 0;
            @(negedge clk);
            while (bus.o_req_ready == 2'b00 && k < 20) begin @(negedge clk); k++; end
            check("alt_grant", bus.o_req_ready, (i % 2) ? 2'b10 : 2'b01);
            @(posedge clk); #1;
            wait_rsp();
            check("alt_id", bus.o_rsp_id, i % 2);
            bus.i_rsp_ready = 1'b1;
            @(posedge clk); #1;
            bus.i_rsp_ready = 1'b0;
        end
        bus.i_req_valid = 2'b00;

        // Reset during CMP discards the request and restores the tie-break
        run_one(0, 32'h2, 32'h2, 3'b000, res);
        @(posedge clk); #1;
        drive_req(0, 32'd7, 32'd9, 3'b100);
        @(negedge clk);
        check("cmp_accept", bus.o_req_ready, 2'b01);
        @(posedge clk); #1;
        bus.i_req_valid = 2'b00;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        drive_req(0, 32'd7, 32'd9, 3'b100);
        drive_req(1, 32'd4, 32'd4, 3'b000);
        @(negedge clk);
        check("rst_cmp_norsp", bus.o_rsp_valid, 0);
        check("rst_cmp_tie", bus.o_req_ready, 2'b01);

        // Randomized traffic; requesters hold payload until accepted
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            acc = rst ? 2'b00 : (bus.i_req_valid & bus.o_req_ready);
            @(posedge clk); #1;
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 199) == 0) rst = 1'b1;
            for (int r = 0; r < 2; r++) begin
                if (!bus.i_req_valid[r] || acc[r]) begin
                    if ($urandom_range(0, 2) != 0) begin
                        a = rnd_op();
                        drive_req(r, a, ($urandom_range(0, 3) == 0) ? a : rnd_op(), 3'($urandom_range(0, 7)));
                    end else begin
                        bus.i_req_valid[r] = 1'b0;
                    end
                end
            end
            bus.i_rsp_ready = ($urandom_range(0, 2) != 0);
        end
        bus.i_req_valid = 2'b00;
        bus.i_rsp_ready = 1'b1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/brc_arb.md
# brc_arb

Shared branch-resolution controller for the RV32I core. Accepts branch-compare requests from two requesters (port 0: branch unit, port 1: debug/trace compare port), arbitrates round-robin, drives a single internal `brc` instance, decodes funct3 into a taken/not-taken decision, and returns a registered response over a valid/ready handshake. Sits between the decode stage and the existing `brc` comparator, which it instantiates.

## Interface

- `CNT_W`, default 16: width of the statistics counters.
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_req_valid`  in  2  per-requester request valid; bit r belongs to requester r.
- `o_req_ready`  out  2  per-requester accept.
- `i_req_rs1`  in  64  operand A; requester r uses bits [32r+31:32r].
- `i_req_rs2`  in  64  operand B; same packing.
- `i_req_funct3`  in  6  branch funct3; requester r uses bits [3r+2:3r].
- `o_rsp_valid`  out  1  response valid.
- `i_rsp_ready`  in  1  response accept.
- `o_rsp_id`  out  1  requester index owning the response.
- `o_rsp_taken`  out  1  branch condition true.
- `o_rsp_less`, `o_rsp_equal`  out  1 each  raw `brc` flags captured for this request.
- `o_rsp_illegal`  out  1  funct3 was 010 or 011.
- `o_stat_total`, `o_stat_taken`  out  CNT_W each  response counters (see Configuration).

## Operation

- FSM states: IDLE, CMP, RESP. Reset state IDLE.
- IDLE: grant = round-robin over `i_req_valid`; with both valid, the requester not granted last wins. `o_req_ready[r]` = (state==IDLE) && grant[r]; at most one bit set. On `i_req_valid[r] && o_req_ready[r]`: latch rs1, rs2, funct3, id=r; update last-grant pointer to r; go CMP.
- CMP: latched operands drive `brc`. `i_br_un` of `brc` is 1 for signed compare, 0 for unsigned: 1 for funct3 100/101, 0 for 110/111, 1 otherwise. Capture `o_br_less`, `o_br_equal`, taken, illegal into response registers; go RESP.
- Taken decode: 000 equal; 001 !equal; 100 less; 101 !less; 110 less; 111 !less; 010/011 taken=0, illegal=1.
- RESP: `o_rsp_valid`=1, response fields stable. On `i_rsp_ready`: go IDLE. No new request accepted in CMP or RESP.
- Requesters must hold valid and payload stable until accepted; ready may depend on valid.

## Timing

- Reset values: `o_req_ready`=00, `o_rsp_valid`=0, `o_rsp_id`=0, `o_rsp_taken`=0, `o_rsp_less`=0, `o_rsp_equal`=0, `o_rsp_illegal`=0, counters 0; last-grant pointer=1 (requester 0 wins first tie).
- Accept at edge N → CMP during cycle N+1 → `o_rsp_valid` high from edge N+2.
- Response handshake at edge M → IDLE in cycle M+1; next accept no earlier than edge M+1. Max throughput one request per 3 cycles.
- `i_rsp_ready` held low: RESP held indefinitely, fields unchanged.
- `i_reset` in any state: next cycle IDLE, pending transaction discarded with no response, pointer and outputs to reset values. Reset dominates a simultaneous handshake.

## Configuration

- `BRC_ARB_STATS_EN` defined: `o_stat_total` increments on every response handshake; `o_stat_taken` increments on handshakes with `o_rsp_taken`=1; both saturate at all-ones; cleared by `i_reset`.
- Not defined: counter logic absent, both outputs tied to 0; all other behaviour identical.

## Test plan

- Reset, then req0 rs1=5, rs2=5, funct3=000 → accepted next edge, `o_rsp_valid` two edges later with id=0, taken=1, equal=1, less=0.
- req1 rs1=0x00000001, rs2=0xFFFFFFFF: funct3=100 → taken=0, less=0; funct3=110 → taken=1, less=1.
- Both valid continuously after reset, funct3=001, distinct operands → grants alternate 0,1,0,1; each response id matches; never two ready bits set.
- `i_rsp_ready`=0 for 10 cycles in RESP → `o_rsp_valid` and fields stable, `o_req_ready`=00; release → IDLE next cycle.
- funct3=011, rs1=rs2=0x80000000 → illegal=1, taken=0, equal=1; with `BRC_ARB_STATS_EN` total increments, taken does not.
- `i_reset` asserted in CMP → no response emitted, next cycle IDLE, requester 0 wins the following tie.
